// File: rtl/flac_enc_pkg.sv
// Shared FLAC encoder constants and types used by predictor, estimator and packer stages.
// No logic or state; nothing to backpressure.
package flac_enc_pkg;
  localparam int FLAC_MAX_RICE_K  = 14;
  localparam int FLAC_RICE_ESCAPE = 15;
  localparam int FLAC_SAMPLE_W    = 16;
  localparam int FLAC_BLOCK_SIZE  = 4096;

  typedef logic [3:0] rice_k_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEARCH
  } search_st_t;
endpackage

// File: rtl/zigzag_map.sv
// Zigzag fold of a signed residual onto an unsigned magnitude (0,-1,1,-2.. -> 0,1,2,3..).
// Purely combinational, zero latency; no flow control.
module zigzag_map #(
  parameter int SAMPLE_W = 16
) (
  input  logic signed [SAMPLE_W-1:0] residual,
  output logic        [SAMPLE_W-1:0] mapped
);
  assign mapped = $unsigned((residual <<< 1) ^ (residual >>> (SAMPLE_W - 1)));
endmodule

// File: rtl/rice_param_estimator.sv
// Accumulates zigzag residual magnitudes per block and searches the smallest Rice k with N<<k >= sum.
// Result pulses oDone 2+k cycles after the last sample; never stalls, so no backpressure port.
module rice_param_estimator
  import flac_enc_pkg::*;
#(
  parameter int SAMPLE_W   = FLAC_SAMPLE_W,
  parameter int BLOCK_SIZE = FLAC_BLOCK_SIZE,
  parameter int LOG2_BLOCK = 12,
  parameter int MAX_K      = FLAC_MAX_RICE_K,
  parameter int SUM_W      = SAMPLE_W + 1 + LOG2_BLOCK
) (
  input  logic                iClock,
  input  logic                iReset_n,
  input  logic                iValid,
  input  logic [SAMPLE_W-1:0] iResidual,
  input  logic                iClear,
  output logic [3:0]          oK,
  output logic [SUM_W-1:0]    oSum,
  output logic                oDone,
  output logic                oBusy
);
  localparam int CMP_W = SUM_W + MAX_K;

  logic [SAMPLE_W-1:0]   mapped;
  logic [SUM_W-1:0]      acc;
  logic [SUM_W-1:0]      acc_next;
  logic [SUM_W-1:0]      search_sum;
  logic [LOG2_BLOCK-1:0] cnt;
  rice_k_t               k;
  search_st_t            state;
  logic                  k_hit;

  zigzag_map #(.SAMPLE_W(SAMPLE_W)) u_zigzag (
    .residual (iResidual),
    .mapped   (mapped)
  );

  assign acc_next = acc + SUM_W'(mapped);

  // Widened so BLOCK_SIZE<<MAX_K cannot wrap before the compare.
  assign k_hit = ((CMP_W'(BLOCK_SIZE) << k) >= CMP_W'(search_sum)) || (k == rice_k_t'(MAX_K));

  assign oBusy = (state == ST_SEARCH);

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      acc        <= '0;
      cnt        <= '0;
      search_sum <= '0;
      k          <= '0;
      state      <= ST_IDLE;
      oK         <= '0;
      oSum       <= '0;
      oDone      <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (iClear) begin
        acc   <= '0;
        cnt   <= '0;
        state <= ST_IDLE;
      end else begin
        if (state == ST_SEARCH) begin
          if (k_hit) begin
            oK    <= k;
            oSum  <= search_sum;
            oDone <= 1'b1;
            state <= ST_IDLE;
          end else begin
            k <= k + 1'b1;
          end
        end
        // Block completion is placed last: it owns k/state if both ever coincide.
        if (iValid) begin
          if (&cnt) begin
            search_sum <= acc_next;
            acc        <= '0;
            cnt        <= '0;
            k          <= '0;
            state      <= ST_SEARCH;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rice_param_estimator.sv
// Directed bench for rice_param_estimator: block sums, k search, latency, clear and async reset.
module tb_rice_param_estimator;
  localparam int SUM_W = 29;

  logic              iClock;
  logic              iReset_n;
  logic              iValid;
  logic [15:0]       iResidual;
  logic              iClear;
  logic [3:0]        oK;
  logic [SUM_W-1:0]  oSum;
  logic              oDone;
  logic              oBusy;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int last_cyc = 0;
  int busy_run = 0;
  int last_busy = 0;

  logic [SUM_W-1:0] done_sum_q[$];
  logic [3:0]       done_k_q[$];
  int               done_cyc_q[$];

  rice_param_estimator dut (
    .iClock    (iClock),
    .iReset_n  (iReset_n),
    .iValid    (iValid),
    .iResidual (iResidual),
    .iClear    (iClear),
    .oK        (oK),
    .oSum      (oSum),
    .oDone     (oDone),
    .oBusy     (oBusy)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  always @(posedge iClock) ncyc <= ncyc + 1;

  always @(negedge iClock) begin
    if (oDone === 1'b1) begin
      done_sum_q.push_back(oSum);
      done_k_q.push_back(oK);
      done_cyc_q.push_back(ncyc);
    end
    if (oBusy === 1'b1) begin
      busy_run = busy_run + 1;
    end else if (busy_run > 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int val, input int n, input bit rnd);
    int sent = 0;
    while (sent < n) begin
      @(negedge iClock);
      iResidual = 16'(val);
      iValid    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (iValid) begin
        sent++;
        last_cyc = ncyc;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iClock);
      iValid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cyc_q.size() < target && n < 64) begin
      @(negedge iClock);
      iValid = 1'b0;
      n++;
    end
    idle(3);
    check({tag, "_done_count"}, done_cyc_q.size(), target);
  endtask

  task automatic check_result(input string tag, input int idx, input int l_cyc,
                              input logic [63:0] sum, input logic [63:0] k);
    if (idx < done_cyc_q.size()) begin
      check({tag, "_sum"}, done_sum_q[idx], sum);
      check({tag, "_k"}, done_k_q[idx], k);
      check({tag, "_latency"}, done_cyc_q[idx] - l_cyc, 2 + k);
    end else begin
      check({tag, "_missing_result"}, 0, 1);
    end
  endtask

  initial begin
    int base;
    int l1;
    iReset_n  = 1'b0;
    iValid    = 1'b0;
    iResidual = '0;
    iClear    = 1'b0;
    repeat (3) @(negedge iClock);
    check("reset_k", oK, 0);
    check("reset_sum", oSum, 0);
    check("reset_done", oDone, 0);
    check("reset_busy", oBusy, 0);
    iReset_n = 1'b1;
    idle(2);

    // All-zero block: k=0, done at T+2, one busy cycle.
    base = done_cyc_q.size();
    send(0, 4096, 1'b0);
    wait_done("zero", base + 1);
    check_result("zero", base, last_cyc, 0, 0);
    check("zero_busy_len", last_busy, 1);

    // Back-to-back -1 then +1 blocks with no gap.
    base = done_cyc_q.size();
    send(-1, 4096, 1'b0);
    l1 = last_cyc;
    send(1, 4096, 1'b0);
    wait_done("b2b", base + 2);
    check_result("neg1", base, l1, 4096, 0);
    check_result("pos1", base + 1, last_cyc, 8192, 1);

    // 50% random valid.
    base = done_cyc_q.size();
    send(100, 4096, 1'b1);
    wait_done("r100", base + 1);
    check_result("r100", base, last_cyc, 819200, 8);

    // Most negative residual: search caps at MAX_K.
    base = done_cyc_q.size();
    send(-32768, 4096, 1'b0);
    wait_done("max", base + 1);
    check_result("max", base, last_cyc, 268431360, 14);
    check("max_busy_len", last_busy, 15);

    // Clear mid-block; sample alongside clear is discarded.
    base = done_cyc_q.size();
    send(5, 1000, 1'b0);
    @(negedge iClock);
    iClear = 1'b1; iValid = 1'b1; iResidual = 16'd7;
    @(negedge iClock);
    iClear = 1'b0; iValid = 1'b0;
    send(1, 4096, 1'b0);
    wait_done("clr_blk", base + 1);
    check_result("clr_blk", base, last_cyc, 8192, 1);

    // Clear during search: no result, outputs held.
    base = done_cyc_q.size();
    send(-32768, 4096, 1'b0);
    @(negedge iClock);
    iValid = 1'b0;
    check("clr_search_busy_before", oBusy, 1);
    iClear = 1'b1;
    @(negedge iClock);
    iClear = 1'b0;
    idle(30);
    check("clr_search_no_done", done_cyc_q.size(), base);
    check("clr_search_k_held", oK, 1);
    check("clr_search_sum_held", oSum, 8192);
    check("clr_search_busy_after", oBusy, 0);

    // Async reset between clock edges during a search.
    base = done_cyc_q.size();
    send(-32768, 4096, 1'b0);
    @(negedge iClock);
    iValid = 1'b0;
    @(negedge iClock);
    #2;
    iReset_n = 1'b0;
    #1;
    check("arst_k", oK, 0);
    check("arst_sum", oSum, 0);
    check("arst_done", oDone, 0);
    check("arst_busy", oBusy, 0);
    @(negedge iClock);
    iReset_n = 1'b1;
    idle(20);
    check("arst_no_done", done_cyc_q.size(), base);
    send(1, 4096, 1'b0);
    wait_done("post_rst", base + 1);
    check_result("post_rst", base, last_cyc, 8192, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
